beep_pattern_gen: RTL and testbench



---
 rtl/beep_pkg.sv | 15 +
 rtl/beep_tone_div.sv | 47 ++++
 rtl/beep_pattern_gen.sv | 122 ++++++++++++
 tb/tb_beep_pattern_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and default timing constants for the beep pattern generator.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam logic [15:0] TONE_DIV_DEF = 16'd2;
  localparam logic [19:0] ON_CNT_DEF   = 20'd10;
  localparam logic [19:0] OFF_CNT_DEF  = 20'd6;
  localparam int          NUM_W_DEF    = 4;

endpackage

// File: rtl/beep_tone_div.sv
// Square-wave tone source: restarts high on clr, toggles every TONE_DIV enabled
// cycles, and is held low whenever it is not enabled.
module beep_tone_div
  import beep_pkg::*;
#(
  parameter logic [15:0] TONE_DIV = TONE_DIV_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tone
);

  logic [15:0] cnt_q, cnt_d;
  logic        tone_q, tone_d;

  always_comb begin
    cnt_d  = '0;
    tone_d = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (en) begin
      if (cnt_q == TONE_DIV - 16'd1) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d  = cnt_q + 16'd1;
        tone_d = tone_q;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/beep_pattern_gen.sv
// Plays N beeps (ON_CNT tone cycles, OFF_CNT silent cycles between beeps) on
// the buzzer pin. Handshake: req/beep_num are accepted only while idle with
// stop low; busy is high for the whole pattern and done pulses for one cycle
// when it ends normally (or immediately for a zero-beep request).
module beep_pattern_gen
  import beep_pkg::*;
#(
  parameter logic [15:0] TONE_DIV = TONE_DIV_DEF,
  parameter logic [19:0] ON_CNT   = ON_CNT_DEF,
  parameter logic [19:0] OFF_CNT  = OFF_CNT_DEF,
  parameter int          NUM_W    = NUM_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             req,
  input  logic [NUM_W-1:0] beep_num,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             beep
);

  localparam logic [NUM_W-1:0] REM_ONE = NUM_W'(1);

  state_e           state_q, state_d;
  logic [19:0]      dur_q, dur_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tone_en, tone_clr;

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !stop) begin
          if (beep_num != '0) begin
            state_d = ON;
            rem_d   = beep_num;
            dur_d   = '0;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ON: begin
        if (stop) begin
          state_d = IDLE;
          dur_d   = '0;
          rem_d   = '0;
        end else if (dur_q == ON_CNT - 20'd1) begin
          dur_d = '0;
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = OFF;
          end
        end else begin
          dur_d = dur_q + 20'd1;
        end
      end
      OFF: begin
        if (stop) begin
          state_d = IDLE;
          dur_d   = '0;
          rem_d   = '0;
        end else if (dur_q == OFF_CNT - 20'd1) begin
          state_d = ON;
          dur_d   = '0;
        end else begin
          dur_d = dur_q + 20'd1;
        end
      end
      default: begin
        state_d = IDLE;
        dur_d   = '0;
        rem_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // The tone divider is driven from the next state so its registered output
  // lines up with busy: high on the very first cycle of each beep.
  assign tone_en  = (state_d == ON);
  assign tone_clr = (state_d == ON) && (state_q != ON);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  beep_tone_div #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (tone_en),
    .clr     (tone_clr),
    .tone    (beep)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Randomized and directed bench for beep_pattern_gen against a per-cycle
// expected-output queue built from the beep timing rules.
module tb_beep_pattern_gen;

  localparam int TONE_DIV = 2;
  localparam int ON_CNT   = 10;
  localparam int OFF_CNT  = 6;
  localparam int NUM_W    = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             req;
  logic [NUM_W-1:0] beep_num;
  logic             stop;
  logic             busy;
  logic             done;
  logic             beep;

  // One entry per future cycle: {beep, busy, done}. Empty means idle zeros.
  logic [2:0] exp_q[$];
  int checks    = 0;
  int failures  = 0;
  int busy_seen = 0;
  int done_seen = 0;

  beep_pattern_gen #(
    .TONE_DIV (16'd2),
    .ON_CNT   (20'd10),
    .OFF_CNT  (20'd6),
    .NUM_W    (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .beep_num (beep_num),
    .stop     (stop),
    .busy     (busy),
    .done     (done),
    .beep     (beep)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Tone is high for the first TONE_DIV cycles of each beep, then alternates.
  task automatic push_pattern(input int n);
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < ON_CNT; j++)
        exp_q.push_back({((j / TONE_DIV) % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0});
      if (b != n - 1)
        for (int j = 0; j < OFF_CNT; j++) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
  endtask

  task automatic cycle(input logic r, input int n, input logic s);
    logic [2:0] e;
    @(negedge sys_clk);
    e = (exp_q.size() != 0) ? exp_q[0] : 3'b000;
    check_val("beep", {31'd0, beep}, {31'd0, e[2]});
    check_val("busy", {31'd0, busy}, {31'd0, e[1]});
    check_val("done", {31'd0, done}, {31'd0, e[0]});
    busy_seen += int'(busy);
    done_seen += int'(done);
    req      = r;
    beep_num = NUM_W'(n);
    stop     = s;
    @(posedge sys_clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (!sys_rst) begin
      if (s && e[1]) exp_q.delete();
      else if (r && !s && !e[1]) begin
        if (n == 0) exp_q.push_back(3'b001);
        else push_pattern(n);
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, 0, 1'b0);
  endtask

  initial begin
    int guard;
    sys_rst  = 1'b1;
    req      = 1'b0;
    stop     = 1'b0;
    beep_num = '0;
    #1;
    check_val("rst_beep", {31'd0, beep}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    idle(5);
    #2 sys_rst = 1'b0;
    idle(50);

    // single beep
    cycle(1'b1, 1, 1'b0);
    idle(14);

    // three beeps: totals over the whole pattern
    busy_seen = 0;
    done_seen = 0;
    cycle(1'b1, 3, 1'b0);
    idle(45);
    check_val("three_busy_len", busy_seen, 3 * ON_CNT + 2 * OFF_CNT);
    check_val("three_done_cnt", done_seen, 1);

    // abort partway through
    done_seen = 0;
    cycle(1'b1, 3, 1'b0);
    idle(14);
    cycle(1'b0, 0, 1'b1);
    idle(10);
    check_val("abort_no_done", done_seen, 0);

    // req while busy is ignored
    busy_seen = 0;
    cycle(1'b1, 2, 1'b0);
    idle(5);
    cycle(1'b1, 5, 1'b0);
    idle(40);
    check_val("ignore_busy_len", busy_seen, 2 * ON_CNT + OFF_CNT);

    // zero beeps
    cycle(1'b1, 0, 1'b0);
    idle(3);

    // back-to-back: request on the done cycle
    cycle(1'b1, 1, 1'b0);
    guard = 0;
    while (!(exp_q.size() == 1 && exp_q[0] == 3'b001) && guard < 50) begin
      cycle(1'b0, 0, 1'b0);
      guard++;
    end
    check_val("b2b_reached_done", {31'd0, guard < 50}, 32'd1);
    cycle(1'b1, 1, 1'b0);
    idle(15);

    // stop in idle blocks a coincident req
    cycle(1'b1, 2, 1'b1);
    idle(3);

    // asynchronous reset mid-pattern
    cycle(1'b1, 2, 1'b0);
    idle(3);
    #5 sys_rst = 1'b1;
    #1;
    check_val("arst_beep", {31'd0, beep}, 32'd0);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    idle(2);
    #3 sys_rst = 1'b0;
    idle(5);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
    end
    idle(260);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
